// File: rtl/alu_resp_packetizer.sv
// Frames a completed ALU result as a byte stream: opcode, reserved, 16-bit LEN,
// then the result bytes LSB first, with AXI-Stream style valid/ready handshaking.
module alu_resp_packetizer #(
    parameter int RESULT_BYTES_P = 4,
    parameter int DATA_WIDTH_P   = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [DATA_WIDTH_P-1:0]                opcode_i,
    input  logic [DATA_WIDTH_P*RESULT_BYTES_P-1:0] result_i,
    input  logic                                   valid_i,
    output logic                                   ready_o,
    output logic [DATA_WIDTH_P-1:0]                m_axis_tdata,
    output logic                                   m_axis_tvalid,
    input  logic                                   m_axis_tready,
    output logic                                   busy_o,
    output logic                                   pkt_done_o
);

    localparam logic [15:0] LEN_C      = 16'(4 + RESULT_BYTES_P);
    localparam logic [2:0]  LAST_IDX_C = 3'(RESULT_BYTES_P - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD
    } state_t;

    state_t                                 state_reg, state_next;
    logic [2:0]                             idx_reg, idx_next;
    logic [DATA_WIDTH_P-1:0]                opcode_reg, opcode_next;
    logic [DATA_WIDTH_P*RESULT_BYTES_P-1:0] result_reg, result_next;
    logic                                   pkt_done_reg, pkt_done_next;

    // Result bytes padded out to 8 entries so the 3-bit index always selects a real slot.
    logic [DATA_WIDTH_P-1:0] res_bytes [8];
    logic [DATA_WIDTH_P-1:0] hdr_byte;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_res_bytes
            if (gi < RESULT_BYTES_P) begin : g_used
                assign res_bytes[gi] = result_reg[gi*DATA_WIDTH_P +: DATA_WIDTH_P];
            end else begin : g_pad
                assign res_bytes[gi] = '0;
            end
        end
    endgenerate

    always_comb begin
        case (idx_reg[1:0])
            2'd0:    hdr_byte = opcode_reg;
            2'd1:    hdr_byte = '0;
            2'd2:    hdr_byte = LEN_C[7:0];
            default: hdr_byte = LEN_C[15:8];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            idx_reg      <= '0;
            opcode_reg   <= '0;
            result_reg   <= '0;
            pkt_done_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            opcode_reg   <= opcode_next;
            result_reg   <= result_next;
            pkt_done_reg <= pkt_done_next;
        end
    end

    // The index restarts at 0 for the payload, so it never needs more than 3 bits.
    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        opcode_next   = opcode_reg;
        result_next   = result_reg;
        pkt_done_next = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        ready_o       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    state_next  = ST_HDR;
                    idx_next    = '0;
                    opcode_next = opcode_i;
                    result_next = result_i;
                end
            end
            ST_HDR: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = hdr_byte;
                if (m_axis_tready) begin
                    if (idx_reg == 3'd3) begin
                        state_next = ST_PAYLOAD;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx_reg + 3'd1;
                    end
                end
            end
            ST_PAYLOAD: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = res_bytes[idx_reg];
                if (m_axis_tready) begin
                    if (idx_reg == LAST_IDX_C) begin
                        state_next    = ST_IDLE;
                        idx_next      = '0;
                        pkt_done_next = 1'b1;
                    end else begin
                        idx_next = idx_reg + 3'd1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                idx_next   = '0;
            end
        endcase
    end

    assign busy_o     = ~ready_o;
    assign pkt_done_o = pkt_done_reg;

endmodule

// File: tb/tb_alu_resp_packetizer.sv
// Bench for alu_resp_packetizer: directed and random packets checked against a byte-list model,
// with a default-size instance and a single-result-byte instance.
module tb_alu_resp_packetizer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [7:0]  opcode;
    logic [31:0] result;
    logic        valid, ready, busy, done, tvalid, tready;
    logic [7:0]  tdata;

    logic [7:0]  b_opcode, b_result, b_tdata;
    logic        b_valid, b_ready, b_busy, b_done, b_tvalid, b_tready;

    alu_resp_packetizer #(.RESULT_BYTES_P(4), .DATA_WIDTH_P(8)) dut (
        .clk(clk), .rst(rst), .opcode_i(opcode), .result_i(result), .valid_i(valid),
        .ready_o(ready), .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
        .m_axis_tready(tready), .busy_o(busy), .pkt_done_o(done)
    );

    alu_resp_packetizer #(.RESULT_BYTES_P(1), .DATA_WIDTH_P(8)) dut_b (
        .clk(clk), .rst(rst), .opcode_i(b_opcode), .result_i(b_result), .valid_i(b_valid),
        .ready_o(b_ready), .m_axis_tdata(b_tdata), .m_axis_tvalid(b_tvalid),
        .m_axis_tready(b_tready), .busy_o(b_busy), .pkt_done_o(b_done)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] got_q[$], exp_q[$], gotb_q[$], expb_q[$];
    int         xfer_cyc[$];
    int         done_cnt = 0, done_cyc = -1, b_done_cnt = 0, acc_cyc = 0;
    logic       ready_at_done = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference packet: opcode, reserved zero, LEN little-endian, result bytes LSB first.
    task automatic model_pkt(input logic [7:0] op, input logic [63:0] res, input int rb,
                             inout logic [7:0] q[$]);
        int len;
        len = 4 + rb;
        q.push_back(op);
        q.push_back(8'h00);
        q.push_back(len[7:0]);
        q.push_back(len[15:8]);
        for (int i = 0; i < rb; i++) q.push_back(res[8*i +: 8]);
    endtask

    task automatic cmp_bytes(input string tag, input logic [7:0] g[$], input logic [7:0] e[$]);
        string s;
        s = "";
        chk({tag, "_len"}, g.size(), e.size());
        for (int i = 0; i < g.size() && i < e.size(); i++) begin
            chk($sformatf("%s_byte%0d", tag, i), g[i], e[i]);
            s = {s, $sformatf(" %02h", g[i])};
        end
        $display("packet %s: %0d bytes:%s", tag, g.size(), s);
    endtask

    // Monitor: bytes are recorded at the negedge preceding the transfer edge.
    logic       stalled = 1'b0, rst_prev = 1'b1;
    logic [7:0] stall_data = 8'h00;
    always @(negedge clk) begin
        if (stalled && !rst_prev) begin
            chk("stall_tvalid", tvalid, 1);
            chk("stall_tdata", tdata, stall_data);
        end
        if (tvalid === 1'b0) chk("idle_tdata", tdata, 0);
        if (!rst && tvalid && tready) begin
            got_q.push_back(tdata);
            xfer_cyc.push_back(cyc);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            ready_at_done = ready;
        end
        if (!rst && b_tvalid && b_tready) gotb_q.push_back(b_tdata);
        if (b_done) b_done_cnt++;
        stalled    = tvalid && !tready && !rst;
        stall_data = tdata;
        rst_prev   = rst;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic clear();
        got_q.delete();
        exp_q.delete();
        xfer_cyc.delete();
        done_cnt = 0;
        done_cyc = -1;
    endtask

    task automatic send(input logic [7:0] op, input logic [31:0] res);
        int k;
        opcode = op;
        result = res;
        valid  = 1'b1;
        for (k = 0; k < 50; k++) begin
            if (ready) break;
            step();
        end
        if (k == 50) chk("send_timeout", 0, 1);
        step();
        acc_cyc = cyc;
        valid   = 1'b0;
    endtask

    // mode 0: tready high, 1: alternate cycles, 2: random
    task automatic wait_bytes(input int n, input int mode);
        int k;
        for (k = 0; k < 400; k++) begin
            if (got_q.size() >= n) break;
            if (mode == 1) tready = ~tready;
            else if (mode == 2) tready = ($urandom_range(0, 3) != 0);
            else tready = 1'b1;
            step();
        end
        chk("wait_bytes_reached", got_q.size() >= n, 1);
        tready = 1'b1;
    endtask

    initial begin
        int k;
        logic [7:0]  rop;
        logic [31:0] rres;

        rst = 1'b1; valid = 1'b1; opcode = 8'h55; result = 32'h1111_2222; tready = 1'b1;
        b_opcode = 8'h00; b_result = 8'h00; b_valid = 1'b0; b_tready = 1'b1;
        repeat (3) step();
        at_neg();
        chk("rst_ready", ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_done", done, 0);
        chk("rst_b_ready", b_ready, 1);
        chk("rst_b_tvalid", b_tvalid, 0);
        step();
        rst = 1'b0; valid = 1'b0;
        at_neg();
        chk("no_accept_in_reset", tvalid, 0);
        step();

        // Basic packet, tready held high
        clear();
        model_pkt(8'hA1, 64'h1234_5678, 4, exp_q);
        send(8'hA1, 32'h1234_5678);
        at_neg();
        chk("first_tvalid", tvalid, 1);
        chk("first_tdata", tdata, 8'hA1);
        chk("busy_in_flight", busy, 1);
        chk("ready_in_flight", ready, 0);
        step();
        wait_bytes(8, 0);
        repeat (2) step();
        cmp_bytes("basic", got_q, exp_q);
        chk("basic_latency", (xfer_cyc.size() > 0) ? xfer_cyc[0] : -1, acc_cyc);
        chk("basic_span", (xfer_cyc.size() >= 8) ? xfer_cyc[7] - xfer_cyc[0] : -1, 7);
        chk("basic_done_cnt", done_cnt, 1);
        chk("basic_done_cyc", done_cyc, (xfer_cyc.size() >= 8) ? xfer_cyc[7] + 1 : -2);
        chk("basic_ready_at_done", ready_at_done, 1);

        // Backpressure on alternate cycles
        clear();
        model_pkt(8'hA1, 64'h1234_5678, 4, exp_q);
        send(8'hA1, 32'h1234_5678);
        wait_bytes(8, 1);
        repeat (2) step();
        cmp_bytes("backpressure", got_q, exp_q);
        chk("bp_done_cnt", done_cnt, 1);

        // Input isolation: inputs change and valid pulses mid-packet
        clear();
        model_pkt(8'hA1, 64'h1234_5678, 4, exp_q);
        send(8'hA1, 32'h1234_5678);
        opcode = 8'hFF; result = 32'hFFFF_FFFF; valid = 1'b1;
        repeat (2) step();
        chk("iso_ready_busy", ready, 0);
        valid = 1'b0;
        wait_bytes(8, 0);
        repeat (4) step();
        cmp_bytes("isolation", got_q, exp_q);
        at_neg();
        chk("iso_idle_tvalid", tvalid, 0);
        chk("iso_idle_ready", ready, 1);
        step();

        // Back-to-back requests with valid held
        clear();
        model_pkt(8'hB2, 64'h0000_0001, 4, exp_q);
        model_pkt(8'hC3, 64'hDEAD_BEEF, 4, exp_q);
        send(8'hB2, 32'h0000_0001);
        opcode = 8'hC3; result = 32'hDEAD_BEEF; valid = 1'b1;
        for (k = 0; k < 50; k++) begin
            if (ready) break;
            step();
        end
        chk("b2b_ready_seen", ready, 1);
        step();
        valid = 1'b0;
        wait_bytes(16, 0);
        repeat (2) step();
        cmp_bytes("back_to_back", got_q, exp_q);
        chk("b2b_gap", (xfer_cyc.size() >= 9) ? xfer_cyc[8] - xfer_cyc[7] : -1, 2);
        chk("b2b_done_cnt", done_cnt, 2);

        // Reset after the fifth byte is accepted
        clear();
        send(8'hD4, 32'hCAFE_F00D);
        wait_bytes(5, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        at_neg();
        chk("abort_tvalid", tvalid, 0);
        chk("abort_ready", ready, 1);
        chk("abort_tdata", tdata, 0);
        chk("abort_done", done, 0);
        repeat (3) step();
        chk("abort_bytes", got_q.size(), 5);
        chk("abort_done_cnt", done_cnt, 0);
        $display("packet abort: %0d bytes before reset", got_q.size());
        clear();
        model_pkt(8'hE5, 64'h0BAD_F00D, 4, exp_q);
        send(8'hE5, 32'h0BAD_F00D);
        wait_bytes(8, 0);
        repeat (2) step();
        cmp_bytes("after_abort", got_q, exp_q);
        chk("after_abort_done", done_cnt, 1);

        // Random packets with random backpressure
        for (int p = 0; p < 6; p++) begin
            clear();
            rop  = 8'($urandom);
            rres = $urandom;
            model_pkt(rop, {32'h0, rres}, 4, exp_q);
            send(rop, rres);
            wait_bytes(8, 2);
            repeat (2) step();
            cmp_bytes($sformatf("random%0d", p), got_q, exp_q);
            chk($sformatf("random%0d_done", p), done_cnt, 1);
        end

        // Single result byte instance
        gotb_q.delete();
        expb_q.delete();
        b_done_cnt = 0;
        model_pkt(8'h7E, 64'h5A, 1, expb_q);
        b_opcode = 8'h7E; b_result = 8'h5A; b_valid = 1'b1;
        for (k = 0; k < 50; k++) begin
            if (b_ready) break;
            step();
        end
        step();
        b_valid = 1'b0;
        for (k = 0; k < 100; k++) begin
            if (gotb_q.size() >= 5) break;
            step();
        end
        repeat (3) step();
        cmp_bytes("rb1", gotb_q, expb_q);
        chk("rb1_done_cnt", b_done_cnt, 1);
        chk("rb1_ready", b_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
